epbg_serial_tx: RTL and testbench

EPBG_SERIAL_TX -- requirements
Module: epbg_serial_tx

---
 rtl/epbg_pkg.sv | 30 +++
 rtl/epbg_serial_tx_if.sv | 27 ++
 rtl/epbg_bit_timer.sv | 48 ++++
 rtl/epbg_serial_tx.sv | 164 ++++++++++++++++
 tb/tb_epbg_serial_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/epbg_pkg.sv
// epbg_pkg -- shared definitions for the serial nibble transmitter.
//   * epbg_state_e         : frame FSM states IDLE..STOP
//   * FRAME_BITS           : serial bits per frame (start + 4 data + parity + stop)
//   * DEFAULT_CLKS_PER_BIT : default bit period in clock cycles
//   * calc_parity()        : parity bit for a data nibble
// Build option: ODD_PARITY_EN selects odd parity (inverted XOR); even parity otherwise.
package epbg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } epbg_state_e;

  localparam int FRAME_BITS           = 7;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  // Parity over the nibble: even weight of data+parity by default, odd weight
  // when ODD_PARITY_EN is defined.
  function automatic logic calc_parity(input logic [3:0] nib);
`ifdef ODD_PARITY_EN
    return ~(^nib);
`else
    return ^nib;
`endif
  endfunction

endpackage

// File: rtl/epbg_serial_tx_if.sv
// epbg_serial_tx_if -- nibble input handshake plus serial/status outputs.
//   in_valid, in_data[3:0] : nibble offer (bit0 is sent first)
//   in_ready               : transmitter accepts a nibble this cycle
//   tx                     : serial line, idle high
//   nib_q[3:0], par_q      : last accepted nibble and its parity bit
//   busy, done             : frame in progress / end-of-frame pulse
// master: nibble producer side. slave: transmitter side.
interface epbg_serial_tx_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       tx;
  logic [3:0] nib_q;
  logic       par_q;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data,
    input  in_ready, tx, nib_q, par_q, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, tx, nib_q, par_q, busy, done
  );
endinterface

// File: rtl/epbg_bit_timer.sv
// epbg_bit_timer -- counts CLKS_PER_BIT cycles per serial bit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   restart     : force the count back to zero (state entry / idle)
//   bit_end     : current cycle is the last cycle of a bit
//   bit_end_nxt : the following cycle will be the last cycle of a bit
import epbg_pkg::*;

module epbg_bit_timer #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end,
  output logic bit_end_nxt
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_r;
  logic [7:0] cnt_next_s;

  // Next count: zero on restart or at the end of a bit, otherwise increment.
  always_comb begin
    cnt_next_s = 8'd0;
    if (restart) begin
      cnt_next_s = 8'd0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_next_s = 8'd0;
    end else begin
      cnt_next_s = cnt_r + 8'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign bit_end     = (cnt_r == LAST_CNT);
  // Lets the top register its done pulse so it lines up with the last cycle.
  assign bit_end_nxt = (cnt_next_s == LAST_CNT);

endmodule

// File: rtl/epbg_serial_tx.sv
// epbg_serial_tx -- serialises a 4-bit nibble as start(0), d0..d3, parity, stop(1),
// each bit held for CLKS_PER_BIT clocks (frame = 7*CLKS_PER_BIT cycles).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : epbg_serial_tx_if.slave (in_valid/in_data/in_ready handshake,
//                tx, nib_q, par_q, busy, done)
// Build option: ODD_PARITY_EN selects odd parity; timing is identical either way.
// All outputs come straight from registers loaded with next-state values.
import epbg_pkg::*;

module epbg_serial_tx #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic            clk,
  input  logic            rst_n,
  epbg_serial_tx_if.slave bus
);

  epbg_state_e state_r;
  epbg_state_e next_state_s;
  logic [1:0]  bit_idx_r;
  logic [1:0]  bit_idx_next_s;
  logic        transfer_s;
  logic        restart_s;
  logic        bit_end_s;
  logic        bit_end_nxt_s;
  logic        tx_next_s;

  logic [3:0]  nib_q_r;
  logic        par_q_r;
  logic        tx_r;
  logic        busy_r;
  logic        in_ready_r;
  logic        done_r;

  epbg_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart_s),
    .bit_end    (bit_end_s),
    .bit_end_nxt(bit_end_nxt_s)
  );

  // Next-state logic; the data bit index wraps only on the move to PARITY.
  always_comb begin
    next_state_s   = state_r;
    bit_idx_next_s = bit_idx_r;
    transfer_s     = 1'b0;
    case (state_r)
      IDLE: begin
        bit_idx_next_s = 2'd0;
        if (bus.in_valid) begin
          transfer_s   = 1'b1;
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          next_state_s = DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_idx_r == 2'd3) begin
            next_state_s   = PARITY;
            bit_idx_next_s = 2'd0;
          end else begin
            next_state_s   = DATA;
            bit_idx_next_s = bit_idx_r + 2'd1;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s   = IDLE;
        bit_idx_next_s = 2'd0;
      end
    endcase
  end

  // Timer is held clear in IDLE and restarted whenever the state changes.
  assign restart_s = (next_state_s != state_r) || (state_r == IDLE);

  // Line level for the coming cycle, so tx can be registered without lag.
  always_comb begin
    tx_next_s = 1'b1;
    case (next_state_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = nib_q_r[bit_idx_next_s];
      PARITY:  tx_next_s = par_q_r;
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

  // State and bit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bit_idx_r <= 2'd0;
    end else begin
      state_r   <= next_state_s;
      bit_idx_r <= bit_idx_next_s;
    end
  end

  // Captured nibble and parity; only a transfer changes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q_r <= 4'd0;
      par_q_r <= 1'b0;
    end else if (transfer_s) begin
      nib_q_r <= bus.in_data;
      par_q_r <= calc_parity(bus.in_data);
    end else begin
      nib_q_r <= nib_q_r;
      par_q_r <= par_q_r;
    end
  end

  // Registered status/line outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      tx_r       <= tx_next_s;
      busy_r     <= (next_state_s != IDLE);
      in_ready_r <= (next_state_s == IDLE);
      done_r     <= (next_state_s == STOP) && bit_end_nxt_s;
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.tx       = tx_r;
  assign bus.nib_q    = nib_q_r;
  assign bus.par_q    = par_q_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_epbg_serial_tx.sv
module tb_epbg_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  epbg_serial_tx_if if0 ();
  epbg_serial_tx_if if1 ();

  logic       v_valid [2];
  logic [3:0] v_data  [2];

  assign if0.in_valid = v_valid[0];
  assign if0.in_data  = v_data[0];
  assign if1.in_valid = v_valid[1];
  assign if1.in_data  = v_data[1];

  epbg_serial_tx #(.CLKS_PER_BIT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  epbg_serial_tx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic       tx_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       rdy_w [2];
  logic       par_w [2];
  logic [3:0] nib_w [2];

  assign tx_w[0]   = if0.tx;
  assign tx_w[1]   = if1.tx;
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign rdy_w[0]  = if0.in_ready;
  assign rdy_w[1]  = if1.in_ready;
  assign par_w[0]  = if0.par_q;
  assign par_w[1]  = if1.par_q;
  assign nib_w[0]  = if0.nib_q;
  assign nib_w[1]  = if1.nib_q;

`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] nib;
    logic       par;
  } vec_t;
  vec_t tbl [16];

  function automatic int cpb(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  // Reference parity from the weight of the nibble.
  function automatic logic ref_par(input logic [3:0] n);
    logic odd_weight;
    odd_weight = (($countones(n) % 2) == 1);
    return odd_weight ^ ODD;
  endfunction

  // Serial bit k of the frame: start, d0..d3, parity, stop.
  function automatic logic ref_bit(input logic [3:0] n, input int k);
    logic [6:0] f;
    f = {1'b1, ref_par(n), n, 1'b0};
    return f[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, " tx"}, tx_w[sel], 1);
    check({tag, " busy"}, busy_w[sel], 0);
    check({tag, " done"}, done_w[sel], 0);
    check({tag, " in_ready"}, rdy_w[sel], 1);
  endtask

  // One full frame: offer n for one cycle, then follow every cycle of the frame.
  task automatic send_frame(input int sel, input logic [3:0] n, input string tag);
    int c;
    int guard;
    c = cpb(sel);
    guard = 0;
    while (!rdy_w[sel] && guard < 200) begin
      tick;
      guard++;
    end
    check({tag, " ready_wait"}, rdy_w[sel], 1);
    v_valid[sel] = 1'b1;
    v_data[sel]  = n;
    tick;
    v_valid[sel] = 1'b0;
    v_data[sel]  = ~n;
    check({tag, " nib_q"}, nib_w[sel], n);
    check({tag, " par_q"}, par_w[sel], ref_par(n));
    for (int i = 0; i < 7 * c; i++) begin
      check($sformatf("%s tx c%0d", tag, i + 1), tx_w[sel], ref_bit(n, i / c));
      check($sformatf("%s done c%0d", tag, i + 1), done_w[sel], (i == 7 * c - 1));
      check($sformatf("%s busy c%0d", tag, i + 1), busy_w[sel], 1);
      tick;
    end
    check_idle(sel, {tag, " post"});
    check({tag, " nib_hold"}, nib_w[sel], n);
  endtask

  logic [3:0] hist [$];

  initial begin
    v_valid[0] = 1'b0;
    v_valid[1] = 1'b0;
    v_data[0]  = 4'd0;
    v_data[1]  = 4'd0;
    rst_n      = 1'b0;

    // Reset: low for three cycles, then released.
    repeat (3) tick;
    for (int s = 0; s < 2; s++) begin
      check_idle(s, "reset_low");
      check("reset_low nib_q", nib_w[s], 0);
      check("reset_low par_q", par_w[s], 0);
    end
    rst_n = 1'b1;
    tick;
    for (int s = 0; s < 2; s++) begin
      check_idle(s, "reset_rel");
      check("reset_rel nib_q", nib_w[s], 0);
      check("reset_rel par_q", par_w[s], 0);
    end

    // Reference frame at 4 clocks/bit.
    send_frame(0, 4'b1011, "frame1011");

    // Minimum timing at 1 clock/bit.
    send_frame(1, 4'b0000, "min0000");

    // All 16 nibbles, table-driven.
    for (int k = 0; k < 16; k++) begin
      tbl[k].nib = 4'(k);
      tbl[k].par = ref_par(4'(k));
    end
    for (int k = 0; k < 16; k++) begin
      send_frame(1, tbl[k].nib, $sformatf("nib%0d", k));
      check($sformatf("tbl par %0d", k), par_w[1], tbl[k].par);
      check($sformatf("tbl weight %0d", k),
            32'(($countones(nib_w[1]) + int'(par_w[1])) % 2), 32'(ODD));
    end

    // in_valid held high with changing data: only IDLE-cycle values are framed.
    begin
      int p;
      int ph;
      logic [3:0] d;
      p = 7 * 4 + 1;
      hist.delete();
      for (int j = 0; j < 4 * p; j++) begin
        v_valid[0] = 1'b1;
        v_data[0]  = 4'($urandom_range(0, 15));
        hist.push_back(v_data[0]);
        tick;
        ph = j % p;
        d  = hist[j - ph];
        if (ph < 7 * 4) begin
          check($sformatf("hold tx e%0d", j), tx_w[0], ref_bit(d, ph / 4));
          check($sformatf("hold busy e%0d", j), busy_w[0], 1);
          check($sformatf("hold done e%0d", j), done_w[0], (ph == 7 * 4 - 1));
          check($sformatf("hold nib e%0d", j), nib_w[0], d);
        end else begin
          check($sformatf("hold gap tx e%0d", j), tx_w[0], 1);
          check($sformatf("hold gap busy e%0d", j), busy_w[0], 0);
        end
      end
      v_valid[0] = 1'b0;
    end

    // Abort: reset at cycle 10 of a frame.
    begin
      int guard;
      guard = 0;
      while (!rdy_w[0] && guard < 200) begin
        tick;
        guard++;
      end
      check("abort ready_wait", rdy_w[0], 1);
      v_valid[0] = 1'b1;
      v_data[0]  = 4'b0110;
      tick;
      v_valid[0] = 1'b0;
      repeat (9) tick;
      check("abort pre busy", busy_w[0], 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle(0, "abort now");
      check("abort nib_q", nib_w[0], 0);
      for (int i = 0; i < 3; i++) begin
        tick;
        check("abort hold done", done_w[0], 0);
        check("abort hold tx", tx_w[0], 1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      check_idle(0, "abort rel");
      send_frame(0, 4'b1001, "after_abort");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
